// File: rtl/cfg_bank_writer.sv
// Programming-side writer for a BL/WL configuration bank: assembles serial frames
// onto the bit lines and pulses one word line per frame, walking rows 0..NUM_WL-1.
module cfg_bank_writer #(
    parameter int NUM_BL   = 6,
    parameter int NUM_WL   = 11,
    parameter int WL_PULSE = 2,
    parameter int ROW_W    = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              cfg_din,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [0:NUM_BL-1] bl,
    output logic [0:NUM_WL-1] wl,
    output logic [ROW_W-1:0]  row_idx,
    output logic              busy,
    output logic              done
);
    localparam int BIT_W = (NUM_BL > 1) ? $clog2(NUM_BL) : 1;
    localparam int PC_W  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BL - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_WL - 1);
    localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(WL_PULSE - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, HOLD, DONE} state_t;

    state_t            state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PC_W-1:0]   pulse_cnt;
    logic [0:NUM_BL-1] frame;
    logic [0:NUM_BL-1] frame_next;
    logic [0:NUM_WL-1] wl_sel;

    assign cfg_ready = (state == LOAD);

    // Frame including the bit being accepted this cycle, so the last bit can
    // reach bl on the same edge it is taken.
    always_comb begin
        frame_next          = frame;
        frame_next[bit_cnt] = cfg_din;
    end

    always_comb begin
        wl_sel = '0;
        for (int i = 0; i < NUM_WL; i++) begin
            wl_sel[i] = (row_idx == ROW_W'(i));
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state     <= IDLE;
            bl        <= '0;
            wl        <= '0;
            row_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame     <= '0;
            bit_cnt   <= '0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    if (start) begin
                        state   <= LOAD;
                        row_idx <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        frame <= frame_next;
                        if (bit_cnt == LAST_BIT) begin
                            bl      <= frame_next;
                            bit_cnt <= '0;
                            state   <= SETUP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                SETUP: begin
                    wl        <= wl_sel;
                    pulse_cnt <= '0;
                    state     <= PULSE;
                end
                PULSE: begin
                    if (pulse_cnt == LAST_PC) begin
                        wl    <= '0;
                        state <= HOLD;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (row_idx == LAST_ROW) begin
                        state <= DONE;
                    end else begin
                        row_idx <= row_idx + 1'b1;
                        bit_cnt <= '0;
                        state   <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_bank_writer.sv
// Bench for cfg_bank_writer: randomized bitstreams checked against per-row
// expected frames, pulse widths and pass timing derived from the frame rules.
module tb_cfg_bank_writer;
    localparam int NUM_BL   = 6;
    localparam int NUM_WL   = 11;
    localparam int WL_PULSE = 2;
    localparam int ROW_W    = 4;
    localparam int NBITS    = NUM_BL * NUM_WL;
    localparam int PASS_CYC = NUM_WL * (NUM_BL + WL_PULSE + 2) + 1;

    logic              prog_clk = 1'b0;
    logic              prog_rst_n;
    logic              start;
    logic              cfg_din;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [0:NUM_BL-1] bl;
    logic [0:NUM_WL-1] wl;
    logic [ROW_W-1:0]  row_idx;
    logic              busy;
    logic              done;

    always #5 prog_clk = ~prog_clk;

    cfg_bank_writer #(
        .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .WL_PULSE(WL_PULSE), .ROW_W(ROW_W)
    ) dut (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start),
        .cfg_din(cfg_din), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .bl(bl), .wl(wl), .row_idx(row_idx), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    logic bits [NBITS];

    // Observations gathered by the monitor, cleared whenever mon_gen changes.
    int                mon_gen = 0;
    int                wl_cnt [NUM_WL];
    logic [0:NUM_BL-1] wl_bl  [NUM_WL];
    int                inv_bad = 0;
    int                row_bad = 0;

    time               start_t;
    int                lost, stall_bad, delay;
    bit                inj_hit, aborted;
    logic              st_done, st_busy;
    logic [0:NUM_WL-1] rst_wl;
    logic [0:NUM_BL-1] rst_bl;
    logic              rst_busy, rst_done, rst_ready;
    logic [ROW_W-1:0]  rst_row;

    function automatic logic [0:NUM_BL-1] exp_frame(input int r);
        logic [0:NUM_BL-1] f;
        for (int j = 0; j < NUM_BL; j++) f[j] = bits[r * NUM_BL + j];
        return f;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < NBITS; i++) begin
            case (mode)
                0:       bits[i] = (i % 3 == 0);
                1:       bits[i] = 1'($urandom_range(1));
                default: bits[i] = 1'b1;
            endcase
        end
    endtask

    initial begin
        int                last_gen;
        logic [0:NUM_BL-1] prev_bl;
        logic              prev_busy, prev_ready;
        last_gen = 0; prev_bl = '0; prev_busy = 1'b0; prev_ready = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (mon_gen != last_gen) begin
                last_gen = mon_gen;
                for (int r = 0; r < NUM_WL; r++) begin
                    wl_cnt[r] = 0;
                    wl_bl[r]  = '0;
                end
                inv_bad = 0;
                row_bad = 0;
            end
            if (prog_rst_n) begin
                if ($countones(wl) > 1) inv_bad++;
                if (wl != '0 && (cfg_ready || !busy)) inv_bad++;
                for (int r = 0; r < NUM_WL; r++) begin
                    if (wl[r]) begin
                        if (row_idx != ROW_W'(r)) row_bad++;
                        if (wl_cnt[r] == 0) wl_bl[r] = bl;
                        else if (wl_bl[r] !== bl) inv_bad++;
                        wl_cnt[r]++;
                    end
                end
                // bl may only move when loading hands a frame over to the pulse phase
                if (busy && prev_busy && !(prev_ready && !cfg_ready) && bl !== prev_bl) inv_bad++;
            end
            prev_bl    = bl;
            prev_busy  = busy;
            prev_ready = cfg_ready;
        end
    end

    // One programming pass: start, stream bits honouring ready, optional stall,
    // random valid drops and a start/reset injection while wl[inj_row] is high.
    task automatic drive_pass(input int stall_at, input int stall_len, input int drop_pct,
                              input int inj_kind, input int inj_row);
        int k, g, stall_left;
        bit stalled, acc;
        k = 0; g = 0; stall_left = 0; stalled = 0;
        lost = 0; stall_bad = 0; inj_hit = 0; aborted = 0; delay = -1;
        mon_gen++;
        @(posedge prog_clk); #1;
        start = 1'b1; cfg_valid = 1'b1; cfg_din = ~bits[0];
        @(posedge prog_clk); start_t = $time; #1;
        st_done = done; st_busy = busy;
        while (k < NBITS && g < 3000) begin
            start = 1'b0;
            if (inj_kind != 0 && !inj_hit && wl[inj_row]) begin
                inj_hit = 1;
                if (inj_kind == 1) start = 1'b1;
                else begin
                    #3; prog_rst_n = 1'b0; #1;
                    rst_wl = wl; rst_bl = bl; rst_busy = busy;
                    rst_done = done; rst_ready = cfg_ready; rst_row = row_idx;
                    aborted = 1;
                    break;
                end
            end
            if (!stalled && k == stall_at && cfg_ready) begin
                stalled = 1; stall_left = stall_len;
            end
            if (stall_left > 0) begin
                stall_left--;
                cfg_valid = 1'b0;
                cfg_din = 1'($urandom_range(1));
                if (!cfg_ready || wl != '0) stall_bad++;
            end else if (drop_pct > 0 && $urandom_range(99) < drop_pct) begin
                cfg_valid = 1'b0;
                cfg_din = 1'($urandom_range(1));
            end else begin
                cfg_valid = 1'b1;
                cfg_din = bits[k];
            end
            if (cfg_ready && !cfg_valid) lost++;
            acc = cfg_valid && cfg_ready;
            @(posedge prog_clk); #1;
            if (acc) k++;
            g++;
        end
        start = 1'b0; cfg_valid = 1'b0;
        if (!aborted) begin
            g = 0;
            while (!done && g < 1000) begin
                @(posedge prog_clk); #1;
                g++;
            end
            if (done) delay = int'(($time - 1 - start_t) / 10);
        end
    endtask

    task automatic test_reset;
        prog_rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        checks++; if (wl !== '0) begin errors++; $display("FAIL reset_wl: got %b want 0", wl); end
        checks++; if (bl !== '0) begin errors++; $display("FAIL reset_bl: got %b want 0", bl); end
        checks++; if (row_idx !== '0) begin errors++; $display("FAIL reset_row: got %0d want 0", row_idx); end
        checks++; if ({busy, done, cfg_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got busy/done/ready=%b want 000", {busy, done, cfg_ready});
        end
        #1; prog_rst_n = 1'b1;
        cfg_valid = 1'b1; cfg_din = 1'b1;
        repeat (4) @(posedge prog_clk);
        #1;
        checks++; if ({busy, cfg_ready} !== 2'b00) begin
            errors++; $display("FAIL idle_ignore: got busy/ready=%b want 00", {busy, cfg_ready});
        end
        checks++; if (bl !== '0) begin errors++; $display("FAIL idle_bl: got %b want 0", bl); end
        cfg_valid = 1'b0;
    endtask

    task automatic test_pattern_pass;
        fill(0);
        drive_pass(-1, 0, 0, 0, 0);
        checks++; if (st_busy !== 1'b1) begin errors++; $display("FAIL p1_busy_on_start: got %b want 1", st_busy); end
        for (int r = 0; r < NUM_WL; r++) begin
            checks++; if (wl_cnt[r] !== WL_PULSE) begin
                errors++; $display("FAIL p1_row%0d_pulse: got %0d cycles want %0d", r, wl_cnt[r], WL_PULSE);
            end
            checks++; if (wl_bl[r] !== exp_frame(r)) begin
                errors++; $display("FAIL p1_row%0d_frame: got %b want %b", r, wl_bl[r], exp_frame(r));
            end
        end
        checks++; if (wl_bl[0] !== 6'b100100) begin errors++; $display("FAIL p1_frame0: got %b want 100100", wl_bl[0]); end
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL p1_invariants: got %0d violations want 0", inv_bad); end
        checks++; if (row_bad !== 0) begin errors++; $display("FAIL p1_row_idx: got %0d mismatches want 0", row_bad); end
        checks++; if (delay !== PASS_CYC) begin errors++; $display("FAIL p1_done_time: got %0d want %0d", delay, PASS_CYC); end
        checks++; if ({busy, done, wl} !== {2'b01, {NUM_WL{1'b0}}}) begin
            errors++; $display("FAIL p1_end_state: got busy=%b done=%b wl=%b want 0 1 0", busy, done, wl);
        end
        checks++; if (row_idx !== ROW_W'(NUM_WL - 1)) begin
            errors++; $display("FAIL p1_end_row: got %0d want %0d", row_idx, NUM_WL - 1);
        end
    endtask

    task automatic test_stall;
        fill(1);
        drive_pass(2 * NUM_BL + 3, 5, 0, 0, 0);
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_ready: got %0d bad cycles want 0", stall_bad); end
        for (int r = 0; r < NUM_WL; r++) begin
            checks++; if (wl_cnt[r] !== WL_PULSE || wl_bl[r] !== exp_frame(r)) begin
                errors++; $display("FAIL stall_row%0d: got %0d cycles bl=%b want %0d bl=%b",
                                   r, wl_cnt[r], wl_bl[r], WL_PULSE, exp_frame(r));
            end
        end
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL stall_invariants: got %0d want 0", inv_bad); end
        checks++; if (delay !== PASS_CYC + 5) begin errors++; $display("FAIL stall_done_time: got %0d want %0d", delay, PASS_CYC + 5); end
    endtask

    task automatic test_start_ignored;
        fill(1);
        drive_pass(-1, 0, 25, 1, 4);
        checks++; if (inj_hit !== 1'b1) begin errors++; $display("FAIL ign_inject: got %b want 1", inj_hit); end
        for (int r = 0; r < NUM_WL; r++) begin
            checks++; if (wl_cnt[r] !== WL_PULSE || wl_bl[r] !== exp_frame(r)) begin
                errors++; $display("FAIL ign_row%0d: got %0d cycles bl=%b want %0d bl=%b",
                                   r, wl_cnt[r], wl_bl[r], WL_PULSE, exp_frame(r));
            end
        end
        checks++; if (inv_bad !== 0 || row_bad !== 0) begin
            errors++; $display("FAIL ign_invariants: got inv=%0d row=%0d want 0 0", inv_bad, row_bad);
        end
        checks++; if (delay !== PASS_CYC + lost) begin
            errors++; $display("FAIL ign_done_time: got %0d want %0d", delay, PASS_CYC + lost);
        end
    endtask

    task automatic test_reset_midpass;
        fill(1);
        drive_pass(-1, 0, 0, 2, 7);
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL rst_inject: got %b want 1", aborted); end
        checks++; if (rst_wl !== '0) begin errors++; $display("FAIL rst_wl: got %b want 0", rst_wl); end
        checks++; if (rst_bl !== '0) begin errors++; $display("FAIL rst_bl: got %b want 0", rst_bl); end
        checks++; if ({rst_busy, rst_done, rst_ready} !== 3'b000) begin
            errors++; $display("FAIL rst_ctrl: got busy/done/ready=%b want 000", {rst_busy, rst_done, rst_ready});
        end
        checks++; if (rst_row !== '0) begin errors++; $display("FAIL rst_row: got %0d want 0", rst_row); end
        @(posedge prog_clk); #2;
        prog_rst_n = 1'b1;
        repeat (2) @(posedge prog_clk);
        fill(1);
        drive_pass(-1, 0, 0, 0, 0);
        for (int r = 0; r < NUM_WL; r++) begin
            checks++; if (wl_cnt[r] !== WL_PULSE || wl_bl[r] !== exp_frame(r)) begin
                errors++; $display("FAIL rerun_row%0d: got %0d cycles bl=%b want %0d bl=%b",
                                   r, wl_cnt[r], wl_bl[r], WL_PULSE, exp_frame(r));
            end
        end
        checks++; if (delay !== PASS_CYC) begin errors++; $display("FAIL rerun_done_time: got %0d want %0d", delay, PASS_CYC); end
    endtask

    task automatic test_restart_from_done;
        repeat (3) @(posedge prog_clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b want 1", done); end
        fill(2);
        drive_pass(-1, 0, 0, 0, 0);
        checks++; if ({st_done, st_busy} !== 2'b01) begin
            errors++; $display("FAIL restart_edge: got done/busy=%b want 01", {st_done, st_busy});
        end
        for (int r = 0; r < NUM_WL; r++) begin
            checks++; if (wl_cnt[r] !== WL_PULSE || wl_bl[r] !== {NUM_BL{1'b1}}) begin
                errors++; $display("FAIL ones_row%0d: got %0d cycles bl=%b want %0d bl=111111",
                                   r, wl_cnt[r], wl_bl[r], WL_PULSE);
            end
        end
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL ones_invariants: got %0d want 0", inv_bad); end
        checks++; if (delay !== PASS_CYC) begin errors++; $display("FAIL ones_done_time: got %0d want %0d", delay, PASS_CYC); end
    endtask

    initial begin
        test_reset();
        test_pattern_pass();
        test_stall();
        test_start_ignored();
        test_reset_midpass();
        test_restart_from_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
